// File: rtl/pcpi_result_serializer_if.sv
// pcpi_result_serializer_if: coprocessor result and host nibble-pin bundle
interface pcpi_result_serializer_if #(parameter int DATA_W = 32);
  logic              pcpi_ready;
  logic              pcpi_wr;
  logic [DATA_W-1:0] pcpi_rd;
  logic              nib_ack;
  logic [3:0]        nib_out;
  logic              nib_valid;
  logic              busy;
  logic              done;
  logic              overflow;
  modport master (
    output pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    input  nib_out, nib_valid, busy, done, overflow
  );
  modport slave (
    input  pcpi_ready, pcpi_wr, pcpi_rd, nib_ack,
    output nib_out, nib_valid, busy, done, overflow
  );
endinterface

// File: rtl/pcpi_result_serializer.sv
// pcpi_result_serializer: streams a captured PCPI result LSB nibble first over an acked 4-bit pin bus; RESULT_PARITY_EN appends an XOR parity nibble
module pcpi_result_serializer #(
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  pcpi_result_serializer_if.slave bus
);
  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = $clog2(NIBBLES + 1);
`ifdef RESULT_PARITY_EN
  localparam int SH_W = DATA_W + 4;
  localparam int LAST = NIBBLES;
`else
  localparam int SH_W = DATA_W;
  localparam int LAST = NIBBLES - 1;
`endif
  typedef enum logic {IDLE, SEND} state_t;
  state_t           state, state_nxt;
  logic [SH_W-1:0]  shreg, load_word;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2, s3;
  logic             done_q, ovf_q;
  logic             capture, ack_rise, last_ack;
  assign capture  = bus.pcpi_ready & bus.pcpi_wr;
  assign ack_rise = s2 & ~s3;
  assign last_ack = (state == SEND) && ack_rise && (cnt == CNT_W'(LAST));
`ifdef RESULT_PARITY_EN
  logic [3:0] par;
  // parity nibble rides above the data so plain right shifts expose it last
  always_comb begin
    par = '0;
    for (int i = 0; i < NIBBLES; i++) par ^= bus.pcpi_rd[i*4 +: 4];
  end
  assign load_word = {par, bus.pcpi_rd};
`else
  assign load_word = bus.pcpi_rd;
`endif
  // ack synchronizer plus history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) {s1, s2, s3} <= 3'b000;
    else     {s1, s2, s3} <= {bus.nib_ack, s1, s2};
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // next state: a capture starts a stream, the final ack ends it
  always_comb begin
    state_nxt = (state == IDLE) ? (capture ? SEND : IDLE) : (last_ack ? IDLE : SEND);
  end
  // shift register and nibble index; captures during SEND never reload
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == IDLE && capture) begin
      shreg <= load_word;
      cnt   <= '0;
    end else if (state == SEND && ack_rise && !last_ack) begin
      shreg <= shreg >> 4;
      cnt   <= cnt + CNT_W'(1);
    end
  end
  // done pulse and sticky overflow, which a fresh accepted capture clears
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= last_ack;
      ovf_q  <= capture ? (state == SEND) : ovf_q;
    end
  end
  // outputs; nib_out reads zero whenever nothing is being offered
  always_comb begin
    bus.nib_valid = (state == SEND);
    bus.busy      = (state == SEND);
    bus.nib_out   = (state == SEND) ? shreg[3:0] : 4'h0;
    bus.done      = done_q;
    bus.overflow  = ovf_q;
  end
endmodule

// File: tb/tb_pcpi_result_serializer.sv
// tb_pcpi_result_serializer: scoreboard bench for pcpi_result_serializer
module tb_pcpi_result_serializer;
`ifdef RESULT_PARITY_EN
  localparam int NACK = 9;
`else
  localparam int NACK = 8;
`endif
  typedef struct {bit is_done; logic [3:0] v;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];
  pcpi_result_serializer_if #(.DATA_W(32)) bus();
  pcpi_result_serializer #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] w, input int n, input bit with_done);
    exp_t e;
    logic [3:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p ^= w[i*4 +: 4];
    for (int i = 0; i < n; i++) begin
      e.is_done = 0;
      e.v = (i < 8) ? w[i*4 +: 4] : p;
      q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1;
      e.v = 0;
      q.push_back(e);
    end
  endtask
  task automatic capture(input logic [31:0] w, input bit wr);
    @(posedge clk); #1;
    bus.pcpi_ready = 1;
    bus.pcpi_wr = wr;
    bus.pcpi_rd = w;
    cyc(1);
    bus.pcpi_ready = 0;
    bus.pcpi_wr = 0;
  endtask
  task automatic ack(input int n);
    for (int i = 0; i < n; i++) begin
      bus.nib_ack = 1;
      cyc(3);
      bus.nib_ack = 0;
      cyc(3);
    end
  endtask
  // monitor: host-acked nibbles and done pulses are popped against the queue
  logic prev_ack = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.nib_ack && !prev_ack && bus.nib_valid) begin
      if (q.size() == 0) check("unexpected_nibble", 32'(bus.nib_out), 32'hx);
      else begin
        e = q.pop_front();
        check("nib_kind", 32'(e.is_done), 32'd0);
        check("nib_out", 32'(bus.nib_out), 32'(e.v));
      end
    end
    if (!rst && bus.done) begin
      if (q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check("done_kind", 32'(e.is_done), 32'd1);
      end
    end
    prev_ack <= bus.nib_ack;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1);
  end
  initial begin
    bus.pcpi_ready = 0;
    bus.pcpi_wr = 0;
    bus.pcpi_rd = 0;
    bus.nib_ack = 0;
    cyc(2);
    rst = 0;
    check("rst_nib_out", 32'(bus.nib_out), 0);
    check("rst_nib_valid", 32'(bus.nib_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    capture(32'hDEADBEEF, 0);
    cyc(2);
    check("nowr_valid", 32'(bus.nib_valid), 0);
    check("nowr_overflow", 32'(bus.overflow), 0);
    check("nowr_busy", 32'(bus.busy), 0);
    push_word(32'h1234ABCD, NACK, 1);
    capture(32'h1234ABCD, 1);
    check("cap_valid", 32'(bus.nib_valid), 1);
    check("cap_nib0", 32'(bus.nib_out), 32'hD);
    capture(32'hDEADBEEF, 0);
    check("nowr_send_overflow", 32'(bus.overflow), 0);
    ack(NACK);
    check("end_busy", 32'(bus.busy), 0);
    check("end_nib_out", 32'(bus.nib_out), 0);
    check("end_valid", 32'(bus.nib_valid), 0);
    push_word(32'hFFFF0000, NACK, 1);
    capture(32'hFFFF0000, 1);
    ack(2);
    capture(32'h0000FFFF, 1);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_stream_intact", 32'(bus.nib_out), 0);
    ack(NACK - 2);
    check("ovf_sticky", 32'(bus.overflow), 1);
    check("ovf_idle", 32'(bus.busy), 0);
    push_word(32'h00000000, NACK, 1);
    capture(32'h00000000, 1);
    check("ovf_cleared", 32'(bus.overflow), 0);
    ack(NACK);
    bus.nib_ack = 1;
    cyc(3);
    push_word(32'h00000005, NACK, 1);
    capture(32'h00000005, 1);
    cyc(5);
    check("held_ack_nib", 32'(bus.nib_out), 32'h5);
    check("held_ack_valid", 32'(bus.nib_valid), 1);
    bus.nib_ack = 0;
    cyc(3);
    ack(NACK);
    push_word(32'hCAFE1234, 3, 0);
    capture(32'hCAFE1234, 1);
    ack(3);
    rst = 1;
    cyc(1);
    rst = 0;
    check("mid_rst_valid", 32'(bus.nib_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_nib_out", 32'(bus.nib_out), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    push_word(32'h87654321, NACK, 1);
    capture(32'h87654321, 1);
    check("post_rst_nib0", 32'(bus.nib_out), 32'h1);
    ack(NACK);
    cyc(4);
    check("queue_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pcpi_result_serializer.md
# pcpi_result_serializer

Downstream stage of the matrix-multiply PCPI coprocessor. Captures the 32-bit `pcpi_rd` result when the coprocessor completes a write-back. Streams it to the host over the 4-bit pin interface, least-significant nibble first. Uses a level/edge handshake with the host because the host clocks the pins far slower than `clk`. This is the return path that mirrors the nibble-serial instruction loader.

## Interface
- `DATA_W`, default 32: result width; must be a multiple of 4; `NIBBLES = DATA_W/4` is derived.
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset is synchronous and active-high; one clock.
- `pcpi_ready` in 1: coprocessor completion strobe, one cycle.
- `pcpi_wr` in 1: result valid qualifier; a capture requires `pcpi_ready & pcpi_wr`.
- `pcpi_rd` in DATA_W: result word, valid when `pcpi_ready` is high.
- `nib_ack` in 1: host acknowledge from a pin; asynchronous to `clk`.
- `nib_out` out 4: current nibble.
- `nib_valid` out 1: high while `nib_out` holds an unacknowledged nibble.
- `busy` out 1: high from capture until the last nibble is acknowledged.
- `done` out 1: one-cycle pulse after the final nibble is acknowledged.
- `overflow` out 1: sticky; a result arrived while busy and was dropped.

## Operation
- `nib_ack` passes through a 2-flop synchronizer plus a history flop. `ack_rise = s2 & ~s3`. Only rising edges advance the stream.
- The state machine has two states.
- **IDLE**:
  - `nib_valid=0`, `busy=0`.
  - On capture (`pcpi_ready & pcpi_wr`): load shift register with `pcpi_rd`, `cnt<=0`, clear `overflow`, go to SEND.
- **SEND**:
  - `nib_valid=1`, `busy=1`, `nib_out=shreg[3:0]`.
  - On `ack_rise`:
    - If `cnt==LAST`: go to IDLE and pulse `done`.
    - Otherwise: shift right by 4, `cnt<=cnt+1`.
  - `LAST = NIBBLES-1`, or `NIBBLES` with parity enabled.
- Capture while in SEND: the word is dropped, `overflow<=1`, and the stream is unaffected. This holds even when it coincides with the final `ack_rise`; there is no same-cycle reload.
- `pcpi_ready` with `pcpi_wr=0`: ignored in every state.
- Acks in IDLE are ignored. The synchronizer keeps running, so `ack_rise` stays edge-accurate.
- `nib_out` is forced to 0 whenever `nib_valid=0`.
- `cnt` is `$clog2(NIBBLES+1)` bits wide. There is no wrap-around; the stream terminates at LAST.

## Timing
- Reset values: `nib_out=0`, `nib_valid=0`, `busy=0`, `done=0`, `overflow=0`, synchronizer flops 0, state IDLE.
- Reset mid-stream aborts the stream with no `done`. All outputs read 0 in the cycle after the reset edge.
- Capture latency: `pcpi_ready&pcpi_wr` sampled at edge N gives `nib_valid=1` with nibble 0 after edge N.
- Ack latency: `nib_ack` first sampled high at edge E gives `ack_rise` in cycle E+1→E+2. `nib_out` advances after edge E+2.
- The host must hold `nib_ack` high for at least 2 `clk` cycles and low for at least 2 cycles between acks.
- An ack held high across a capture does not advance the stream. The host must drop and re-raise it.
- `done` is high in the cycle after the edge that consumed the final `ack_rise`. `busy` and `nib_valid` fall at the same edge.
- A new capture is accepted at the earliest in the cycle in which `done` is high.

## Configuration
- Macro: `RESULT_PARITY_EN`.
- When defined:
  - At capture, an extra nibble register is loaded with the XOR of all `NIBBLES` data nibbles.
  - It is sent as nibble index `NIBBLES`, after the data, for `NIBBLES+1` acks total.
  - `done` follows the parity nibble.
- When undefined:
  - The parity logic is absent.
  - Exactly `NIBBLES` nibbles are sent and `done` follows the last data nibble.

## Test plan
- Capture `0x1234ABCD` (parity off) with 8 clean acks → `nib_out` sequence D,C,B,A,4,3,2,1. `done` pulses once after the 8th ack, then `busy=0` and `nib_out=0`.
- Parity on, capture `0x1234ABCD` → the 8 data nibbles as above, then a 9th nibble `0x4`. `done` only after the 9th ack.
- Capture `0xFFFF0000`, then a second capture `0x0000FFFF` after 2 acks → `overflow=1` and the stream continues with 0,0,F,F,F,F (first word intact). A next capture in IDLE clears `overflow`.
- Hold `nib_ack=1` before and through a capture of `0x00000005` → nibble 5 is stays on `nib_out` until ack goes low for 2+ cycles and rises again.
- Assert `rst` for one cycle after 3 acks → all outputs 0 next cycle with no `done`. A following capture of `0x87654321` streams starting from nibble 1.
- Pulse `pcpi_ready=1` with `pcpi_wr=0` and `pcpi_rd=0xDEADBEEF` → no state change, `nib_valid` stays 0, `overflow` stays 0.
